// File: rtl/vga_frame_reader_if.sv
// RAM read port and RGB332 pixel stream bundle for vga_frame_reader.
// master = frame reader side, slave = RAM / VGA timing side.
interface vga_frame_reader_if #(
  parameter int ADDR_W = 15
) ();
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_clken;
  logic [31:0]       mem_readdata;
  logic [7:0]        pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    output mem_address, mem_chipselect, mem_clken,
    input  mem_readdata,
    output pix_data, pix_valid, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_clken,
    output mem_readdata,
    input  pix_data, pix_valid, pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/vga_frame_reader.sv
// Streams a whole frame from the 32-bit frame RAM as RGB332 pixels (byte 0 first).
// Optional macro VGA_FRAME_READER_BASE_EN adds base_addr for double-buffered frames.
module vga_frame_reader #(
  parameter int H_PIXELS   = 320,
  parameter int V_LINES    = 240,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
`ifdef VGA_FRAME_READER_BASE_EN
  input  logic [ADDR_W-1:0]   base_addr,
`endif
  vga_frame_reader_if.master  bus,
  output logic                busy
);
  localparam int WORDS = H_PIXELS * V_LINES / 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int X_W   = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int Y_W   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(V_LINES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] base_q;
  logic              rd_vld_p1;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W:0]    occupied;
  logic [1:0]        byte_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic              room, strobe, frame_start, valid, xfer, pop, last_pix;

  function automatic logic [7:0] unpack_byte(input logic [31:0] w, input logic [1:0] sel);
    return w[8*sel +: 8];
  endfunction

  // The in-flight read reserves a FIFO slot so a return can never overflow.
  assign occupied = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_vld_p1};
  assign room     = occupied < (CNT_W+1)'(FIFO_DEPTH);
  assign valid    = (count_q != '0);
  assign xfer     = valid && bus.pix_ready;
  assign pop      = xfer && (byte_q == 2'd3);
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d     = state_q;
    strobe      = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = FETCH;
          frame_start = 1'b1;
        end
      end
      FETCH: begin
        if (room) begin
          strobe = 1'b1;
          if (rd_addr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && last_pix) begin
          if (enable) begin
            state_d     = FETCH;
            frame_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0 -> p1: strobe issued, read data returns one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      base_q    <= '0;
      rd_vld_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_p1 <= strobe;
      if (frame_start) begin
        rd_addr_q <= '0;
`ifdef VGA_FRAME_READER_BASE_EN
        base_q    <= base_addr;
`endif
      end else if (strobe) begin
        rd_addr_q <= (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
      end
    end
  end

  // Stage p1 -> FIFO: capture the returned word.
  always_ff @(posedge clk) begin
    if (rd_vld_p1) fifo_mem[wr_ptr_q] <= bus.mem_readdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      byte_q   <= 2'd0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      if (rd_vld_p1) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({rd_vld_p1, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (xfer) begin
        byte_q <= byte_q + 2'd1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
        end else begin
          x_q <= x_q + X_W'(1);
        end
      end else if (frame_start) begin
        byte_q <= 2'd0;
        x_q    <= '0;
        y_q    <= '0;
      end
    end
  end

  assign bus.mem_address    = base_q + rd_addr_q;
  assign bus.mem_chipselect = strobe;
  assign bus.mem_clken      = 1'b1;
  assign bus.pix_valid      = valid;
  assign bus.pix_data       = valid ? unpack_byte(fifo_mem[rd_ptr_q], byte_q) : 8'd0;
  assign bus.pix_sof        = valid && (x_q == '0) && (y_q == '0);
  assign bus.pix_eol        = valid && (x_q == X_LAST);
  assign busy               = (state_q != IDLE);
endmodule
